up_fetch_seq: RTL and testbench

Parametrised fetch/phase sequencer for the Nibbler-class microprocessor core. It replaces the fixed 2-phase fetch/execute toggle with a 3-state sequencer.
- Holds the program counter and drives the ROM address.
- Latches instr/oprnd from the program byte.
- Fetches an extension byte for long (jump-class) opcodes, then applies taken branches in the execute phase.
- Sits between program ROM and decode/ALU logic.

---
 rtl/up_defs.sv | 20 ++
 rtl/up_pc_reg.sv | 39 +++
 rtl/up_fetch_seq.sv | 139 +++++++++++++
 tb/tb_up_fetch_seq.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/up_defs.sv
// Shared definitions for the Nibbler-class fetch/phase sequencer.
//   state_e       : sequencer state encodings (FETCH, EXT, EXEC)
//   ADDR_W_DEF    : default program counter / ROM address width
//   INSTR_W_DEF   : default opcode field width
//   OPRND_W_DEF   : default operand field width
//   LONG_OPS_DEF  : default long-opcode mask (opcodes 12..15 carry an extension byte)
package up_defs;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXT   = 2'd1,
    EXEC  = 2'd2
  } state_e;

  localparam int unsigned ADDR_W_DEF  = 12;
  localparam int unsigned INSTR_W_DEF = 4;
  localparam int unsigned OPRND_W_DEF = 4;
  localparam logic [15:0] LONG_OPS_DEF = 16'hF000;

endpackage

// File: rtl/up_pc_reg.sv
// Program counter register with async active-high reset, hold, increment and
// parallel load. Load has priority over increment; nothing changes while i_en=0.
// Ports:
//   clock      : system clock, rising edge
//   reset      : asynchronous active-high reset (PC -> 0)
//   i_en       : 1 = register may update this edge (0 = hold)
//   i_inc      : increment PC (wraps at 2^ADDR_W-1 -> 0)
//   i_load     : load i_load_val
//   i_load_val : parallel load value
//   o_pc       : current program counter
module up_pc_reg #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_en,
  input  logic              i_inc,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_val,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc <= '0;
    end else if (i_en) begin
      if (i_load) begin
        r_pc <= i_load_val;
      end else if (i_inc) begin
        r_pc <= r_pc + ADDR_W'(1);
      end
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/up_fetch_seq.sv
// Fetch/phase sequencer: FETCH -> (EXT ->) EXEC -> FETCH. Holds the PC, latches
// opcode/operand and, for long opcodes, an extension byte; applies taken
// branches of long ops in EXEC.
// Optional feature macro: UP_FETCH_RETIRE_CNT_EN adds retire_cnt / branch_cnt.
// Ports:
//   clock, reset  : rising-edge clock, async active-high reset
//   stall         : 1 = freeze sequencer, PC and all registers
//   program_byte  : ROM data at address PC
//   branch_taken  : branch decision, used only in EXEC of a long op
//   PC            : ROM address
//   phase         : 0 = fetch (FETCH/EXT), 1 = execute
//   ext_phase     : 1 while fetching the extension byte
//   instr, oprnd  : latched opcode / operand
//   ext_byte      : latched extension byte
//   is_long       : LONG_OPS[instr]
//   jump_addr     : {oprnd, ext_byte}
//   retire_cnt    : (macro only) count of retired instructions
//   branch_cnt    : (macro only) count of taken long branches
module up_fetch_seq
  import up_defs::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned INSTR_W = INSTR_W_DEF,
  parameter int unsigned OPRND_W = OPRND_W_DEF,
  parameter logic [(1<<INSTR_W)-1:0] LONG_OPS = LONG_OPS_DEF
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       stall,
  input  logic [INSTR_W+OPRND_W-1:0] program_byte,
  input  logic                       branch_taken,
  output logic [ADDR_W-1:0]          PC,
  output logic                       phase,
  output logic                       ext_phase,
  output logic [INSTR_W-1:0]         instr,
  output logic [OPRND_W-1:0]         oprnd,
  output logic [INSTR_W+OPRND_W-1:0] ext_byte,
  output logic                       is_long,
  output logic [ADDR_W-1:0]          jump_addr
`ifdef UP_FETCH_RETIRE_CNT_EN
  ,
  output logic [15:0]                retire_cnt,
  output logic [15:0]                branch_cnt
`endif
);

  localparam int unsigned BYTE_W = INSTR_W + OPRND_W;

  state_e             r_state, w_state_nxt;
  logic [INSTR_W-1:0] r_instr;
  logic [OPRND_W-1:0] r_oprnd;
  logic [BYTE_W-1:0]  r_ext_byte;
  logic               w_pc_inc, w_pc_load, w_is_long;
  logic [ADDR_W-1:0]  w_jump_addr;
  logic [INSTR_W-1:0] w_byte_op;

  assign w_byte_op   = program_byte[BYTE_W-1:OPRND_W];
  assign w_is_long   = LONG_OPS[r_instr];
  assign w_jump_addr = {r_oprnd, r_ext_byte};

  always_comb begin
    w_state_nxt = r_state;
    w_pc_inc    = 1'b0;
    w_pc_load   = 1'b0;
    unique case (r_state)
      FETCH: begin
        w_pc_inc    = 1'b1;
        w_state_nxt = LONG_OPS[w_byte_op] ? EXT : EXEC;
      end
      EXT: begin
        w_pc_inc    = 1'b1;
        w_state_nxt = EXEC;
      end
      EXEC: begin
        w_pc_load   = w_is_long & branch_taken;
        w_state_nxt = FETCH;
      end
      default: w_state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= FETCH;
      r_instr    <= '0;
      r_oprnd    <= '0;
      r_ext_byte <= '0;
    end else if (!stall) begin
      r_state <= w_state_nxt;
      if (r_state == FETCH) begin
        r_instr <= w_byte_op;
        r_oprnd <= program_byte[OPRND_W-1:0];
      end
      if (r_state == EXT) begin
        r_ext_byte <= program_byte;
      end
    end
  end

  up_pc_reg #(
    .ADDR_W(ADDR_W)
  ) u_pc_reg (
    .clock      (clock),
    .reset      (reset),
    .i_en       (!stall),
    .i_inc      (w_pc_inc),
    .i_load     (w_pc_load),
    .i_load_val (w_jump_addr),
    .o_pc       (PC)
  );

`ifdef UP_FETCH_RETIRE_CNT_EN
  logic [15:0] r_retire_cnt, r_branch_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_retire_cnt <= '0;
      r_branch_cnt <= '0;
    end else if (!stall && r_state == EXEC) begin
      r_retire_cnt <= r_retire_cnt + 16'd1;
      if (w_pc_load) begin
        r_branch_cnt <= r_branch_cnt + 16'd1;
      end
    end
  end

  assign retire_cnt = r_retire_cnt;
  assign branch_cnt = r_branch_cnt;
`endif

  assign phase     = (r_state == EXEC);
  assign ext_phase = (r_state == EXT);
  assign instr     = r_instr;
  assign oprnd     = r_oprnd;
  assign ext_byte  = r_ext_byte;
  assign is_long   = w_is_long;
  assign jump_addr = w_jump_addr;

endmodule

// File: tb/tb_up_fetch_seq.sv
// Directed bench for up_fetch_seq: a per-cycle vector table driving a small
// program (short ops, long ops taken / not taken, stalls, branch to 12'hFFF and
// wrap), then hand-written sequences for long-op wrap, branch-to-self and an
// asynchronous reset between clock edges.
module tb_up_fetch_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [7:0]  program_byte;
  logic [11:0] PC;
  logic        phase, ext_phase, is_long;
  logic [3:0]  instr, oprnd;
  logic [7:0]  ext_byte;
  logic [11:0] jump_addr;
`ifdef UP_FETCH_RETIRE_CNT_EN
  logic [15:0] retire_cnt, branch_cnt;
`endif

  logic [7:0] rom [0:4095];
  assign program_byte = rom[PC];

  always #5 clock = ~clock;

  up_fetch_seq dut (
    .clock        (clock),
    .reset        (reset),
    .stall        (stall),
    .program_byte (program_byte),
    .branch_taken (branch_taken),
    .PC           (PC),
    .phase        (phase),
    .ext_phase    (ext_phase),
    .instr        (instr),
    .oprnd        (oprnd),
    .ext_byte     (ext_byte),
    .is_long      (is_long),
    .jump_addr    (jump_addr)
`ifdef UP_FETCH_RETIRE_CNT_EN
    ,
    .retire_cnt   (retire_cnt),
    .branch_cnt   (branch_cnt)
`endif
  );

  typedef struct packed {
    logic        stall;
    logic        bt;
    logic [11:0] pc;
    logic        phase;
    logic        extp;
    logic [3:0]  instr;
    logic [3:0]  oprnd;
    logic [7:0]  ext;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Full visible state check; is_long and jump_addr follow from instr/oprnd/ext.
  task automatic chk_all(input string tag, input logic [11:0] e_pc, input logic e_ph,
                         input logic e_xp, input logic [3:0] e_in, input logic [3:0] e_op,
                         input logic [7:0] e_ext);
    chk({tag, " PC"}, 32'(PC), 32'(e_pc));
    chk({tag, " phase"}, 32'(phase), 32'(e_ph));
    chk({tag, " ext_phase"}, 32'(ext_phase), 32'(e_xp));
    chk({tag, " instr"}, 32'(instr), 32'(e_in));
    chk({tag, " oprnd"}, 32'(oprnd), 32'(e_op));
    chk({tag, " ext_byte"}, 32'(ext_byte), 32'(e_ext));
    chk({tag, " is_long"}, 32'(is_long), 32'(e_in >= 4'hC));
    chk({tag, " jump_addr"}, 32'(jump_addr), 32'({e_op, e_ext}));
  endtask

  task automatic step(input logic s, input logic bt);
    stall = s;
    branch_taken = bt;
    @(posedge clock);
    #1;
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) rom[a] = 8'h00;
    rom[12'h000] = 8'h12;
    rom[12'h001] = 8'hF3;
    rom[12'h002] = 8'h45;
    rom[12'h003] = 8'hF3;
    rom[12'h004] = 8'h67;
    rom[12'h367] = 8'h12;
    rom[12'h368] = 8'hFF;
    rom[12'h369] = 8'hFF;
    rom[12'hFFF] = 8'h12;

    //              stall bt    pc      ph    xp    in    op    ext
    vecs[0]  = '{1'b0, 1'b0, 12'h001, 1'b1, 1'b0, 4'h1, 4'h2, 8'h00}; // fetch short 12
    vecs[1]  = '{1'b0, 1'b1, 12'h001, 1'b0, 1'b0, 4'h1, 4'h2, 8'h00}; // bt ignored, short
    vecs[2]  = '{1'b0, 1'b0, 12'h002, 1'b0, 1'b1, 4'hF, 4'h3, 8'h00}; // fetch long F3
    vecs[3]  = '{1'b0, 1'b0, 12'h003, 1'b1, 1'b0, 4'hF, 4'h3, 8'h45}; // ext 45
    vecs[4]  = '{1'b0, 1'b0, 12'h003, 1'b0, 1'b0, 4'hF, 4'h3, 8'h45}; // not taken
    vecs[5]  = '{1'b0, 1'b0, 12'h004, 1'b0, 1'b1, 4'hF, 4'h3, 8'h45}; // fetch long F3
    vecs[6]  = '{1'b1, 1'b1, 12'h004, 1'b0, 1'b1, 4'hF, 4'h3, 8'h45}; // stall in EXT
    vecs[7]  = '{1'b1, 1'b1, 12'h004, 1'b0, 1'b1, 4'hF, 4'h3, 8'h45};
    vecs[8]  = '{1'b1, 1'b0, 12'h004, 1'b0, 1'b1, 4'hF, 4'h3, 8'h45};
    vecs[9]  = '{1'b0, 1'b0, 12'h005, 1'b1, 1'b0, 4'hF, 4'h3, 8'h67}; // resume, ext 67
    vecs[10] = '{1'b0, 1'b1, 12'h367, 1'b0, 1'b0, 4'hF, 4'h3, 8'h67}; // taken -> 367
    vecs[11] = '{1'b0, 1'b1, 12'h368, 1'b1, 1'b0, 4'h1, 4'h2, 8'h67}; // short, ext kept
    vecs[12] = '{1'b0, 1'b1, 12'h368, 1'b0, 1'b0, 4'h1, 4'h2, 8'h67};
    vecs[13] = '{1'b0, 1'b0, 12'h369, 1'b0, 1'b1, 4'hF, 4'hF, 8'h67}; // fetch long FF
    vecs[14] = '{1'b0, 1'b0, 12'h36A, 1'b1, 1'b0, 4'hF, 4'hF, 8'hFF}; // ext FF
    vecs[15] = '{1'b1, 1'b1, 12'h36A, 1'b1, 1'b0, 4'hF, 4'hF, 8'hFF}; // stall in EXEC
    vecs[16] = '{1'b0, 1'b1, 12'hFFF, 1'b0, 1'b0, 4'hF, 4'hF, 8'hFF}; // taken -> FFF
    vecs[17] = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 4'h1, 4'h2, 8'hFF}; // fetch at FFF wraps
    vecs[18] = '{1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 4'h1, 4'h2, 8'hFF};

    // Reset released 2 ns in, well before the first rising edge at 5 ns.
    #2;
    reset = 1'b0;
    #1;
    chk_all("reset", 12'h000, 1'b0, 1'b0, 4'h0, 4'h0, 8'h00);
`ifdef UP_FETCH_RETIRE_CNT_EN
    chk("reset retire_cnt", 32'(retire_cnt), 32'd0);
    chk("reset branch_cnt", 32'(branch_cnt), 32'd0);
`endif

    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].stall, vecs[i].bt);
      chk_all($sformatf("row%0d", i), vecs[i].pc, vecs[i].phase, vecs[i].extp,
              vecs[i].instr, vecs[i].oprnd, vecs[i].ext);
    end
`ifdef UP_FETCH_RETIRE_CNT_EN
    // Retired: rows 1,4,10,12,16,18; taken long branches: rows 10,16.
    chk("table retire_cnt", 32'(retire_cnt), 32'd6);
    chk("table branch_cnt", 32'(branch_cnt), 32'd2);
`endif

    // Long op at 12'hFFF: extension byte comes from address 0.
    reset = 1'b1;
    rom[12'h000] = 8'hFF;
    rom[12'h001] = 8'hFF;
    rom[12'hFFF] = 8'hF1;
    rom[12'h1FF] = 8'hF1;
    rom[12'h200] = 8'hFF;
    #2;
    reset = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("wrap pre PC", 32'(PC), 32'hFFF);
    step(1'b0, 1'b0);
    chk_all("wrapL fetch", 12'h000, 1'b0, 1'b1, 4'hF, 4'h1, 8'hFF);
    step(1'b0, 1'b0);
    chk_all("wrapL ext", 12'h001, 1'b1, 1'b0, 4'hF, 4'h1, 8'hFF);
    step(1'b0, 1'b1);
    chk("wrapL exec PC", 32'(PC), 32'h1FF);

    // Branch to its own address re-fetches the same instruction.
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("self ext PC", 32'(PC), 32'h201);
    step(1'b0, 1'b1);
    chk("self exec PC", 32'(PC), 32'h1FF);
    step(1'b0, 1'b0);
    chk_all("self refetch", 12'h200, 1'b0, 1'b1, 4'hF, 4'h1, 8'hFF);

    // Asynchronous reset between edges while in EXT.
    #2;
    reset = 1'b1;
    #1;
    chk_all("async rst", 12'h000, 1'b0, 1'b0, 4'h0, 4'h0, 8'h00);
`ifdef UP_FETCH_RETIRE_CNT_EN
    chk("async rst retire_cnt", 32'(retire_cnt), 32'd0);
    chk("async rst branch_cnt", 32'(branch_cnt), 32'd0);
`endif
    #1;
    reset = 1'b0;
    step(1'b0, 1'b0);
    chk_all("post rst fetch", 12'h001, 1'b0, 1'b1, 4'hF, 4'hF, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
